// File: rtl/xps2_rx_fifo.sv
// PS/2 keyboard receiver: pin synchronizer, 11-bit frame assembler with
// start/parity/stop checking and timeout, and a small scancode FIFO on the data bus.
module xps2_rx_fifo #(
  parameter int FIFO_AW     = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  input  logic        data_sel,
  input  logic        data_we,
  input  logic        data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        irq
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  logic             clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
  logic             fall;
  logic [1:0]       state;
  logic [10:0]      sr;
  logic [3:0]       bitcnt;
  logic [TW-1:0]    tmo;
  logic             frame_good, frame_bad, timeout_hit;
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
  logic [FIFO_AW:0] count;
  logic             empty, full, pop, push_ok, flush, clr, st_wr;
  logic             ovf, frame_err;
  logic [3:0]       cnt4;
  logic             unused_bits;

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= PS2_CLK;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= PS2_DATA;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // sr fills from the top, so a full frame lands as {stop, parity, data, start}
  assign frame_good  = (state == S_CHECK) & ~sr[0] & sr[10] & (^sr[9:1]);
  assign frame_bad   = (state == S_CHECK) & ~frame_good;
  assign timeout_hit = (state == S_SHIFT) & ~fall & (tmo == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      sr     <= '0;
      bitcnt <= '0;
      tmo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          bitcnt <= '0;
          tmo    <= '0;
          if (fall && !dat_s2) begin
            sr     <= {dat_s2, sr[10:1]};
            bitcnt <= 4'd1;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (fall) begin
            sr     <= {dat_s2, sr[10:1]};
            bitcnt <= bitcnt + 4'd1;
            tmo    <= '0;
            if (bitcnt == 4'd10) state <= S_CHECK;
          end else if (timeout_hit) begin
            state  <= S_IDLE;
            bitcnt <= '0;
            tmo    <= '0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_CHECK: begin
          state  <= S_IDLE;
          bitcnt <= '0;
          tmo    <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == (FIFO_AW + 1)'(DEPTH));
  assign pop     = data_sel & ~data_we & ~data_addr & ~empty;
  assign st_wr   = data_sel & data_we & data_addr;
  assign clr     = st_wr & data_in[0];
  assign flush   = st_wr & data_in[1];
  // a simultaneous pop frees the slot, so a full FIFO still accepts the byte
  assign push_ok = frame_good & (~full | pop) & ~flush;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= sr[8:1];
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (frame_good && full && !pop && !flush) ovf <= 1'b1;
      else if (clr)                             ovf <= 1'b0;
      if (frame_bad || timeout_hit) frame_err <= 1'b1;
      else if (clr)                 frame_err <= 1'b0;
    end
  end

  assign cnt4 = 4'(count);

  always_comb begin
    data_out = '0;
    if (data_sel) begin
      if (!data_addr)
        data_out = {23'd0, ~empty, (empty ? 8'h00 : mem[rd_ptr])};
      else
        data_out = {24'd0, ovf, frame_err, (state != S_IDLE), cnt4, ~empty};
    end
  end

  assign irq         = ~empty;
  assign unused_bits = ^data_in[31:2];
endmodule
